// File: rtl/sha3_absorb_rx.sv
// sha3_absorb_rx: packs a 16-bit byte stream into SHA3 rate blocks and applies 0x06..0x80 padding.
module sha3_absorb_rx #(
    parameter int WIDTH    = 16,
    parameter int RATE_MAX = 1152
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic [WIDTH-1:0]    s_axis_tdata,
    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    input  logic                s_axis_tlast,
    input  logic [1:0]          s_axis_tkeep,
    input  logic [1:0]          s_axis_tuser,
    output logic                blk_valid,
    input  logic                blk_ready,
    output logic [RATE_MAX-1:0] blk_data,
    output logic                blk_last,
    output logic [1:0]          blk_mode
);
    typedef enum logic [1:0] {FILL, OUT, EXTRA} state_t;
    state_t              state_q, state_d;
    logic [6:0]          wcnt_q, wcnt_d, rw;
    logic [RATE_MAX-1:0] blk_q, blk_d;
    logic [1:0]          mode_q, mode_d, cur_mode, nkeep;
    logic                extra_q, extra_d, last_q, last_d, in_msg_q, in_msg_d, run_q, acc;
    logic [7:0]          rate_b, p;
    logic [10:0]         woff, poff, roff;
    // the mode only follows tuser on the first beat of a message
    assign cur_mode      = (state_q == FILL && !in_msg_q) ? s_axis_tuser : mode_q;
    assign rw            = cur_mode == 2'd0 ? 7'd72 : cur_mode == 2'd1 ? 7'd68 : cur_mode == 2'd2 ? 7'd52 : 7'd36;
    assign rate_b        = {rw, 1'b0};
    assign s_axis_tready = run_q && state_q == FILL;
    assign acc           = s_axis_tvalid && s_axis_tready;
    assign nkeep         = !s_axis_tlast ? 2'd2 : s_axis_tkeep[1] ? (s_axis_tkeep[0] ? 2'd2 : 2'd1) : 2'd0;
    assign p             = {wcnt_q, 1'b0} + {6'd0, nkeep};
    assign woff          = {wcnt_q, 4'd0};
    assign poff          = {p, 3'd0};
    assign roff          = {rate_b - 8'd1, 3'd0};
    assign blk_valid     = state_q == OUT;
    assign blk_data      = blk_q;
    assign blk_last      = state_q == OUT && last_q;
    assign blk_mode      = mode_q;
    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        blk_d    = blk_q;
        mode_d   = mode_q;
        extra_d  = extra_q;
        last_d   = last_q;
        in_msg_d = in_msg_q;
        case (state_q)
            FILL: if (acc) begin
                mode_d   = cur_mode;
                in_msg_d = !s_axis_tlast;
                wcnt_d   = wcnt_q + 7'd1;
                if (nkeep != 2'd0) blk_d[woff +: 8] = s_axis_tdata[15:8];
                if (nkeep == 2'd2) blk_d[woff + 11'd8 +: 8] = s_axis_tdata[7:0];
                if (!s_axis_tlast) begin
                    if (wcnt_q == rw - 7'd1) begin
                        state_d = OUT;
                        last_d  = 1'b0;
                    end
                end else if (p == rate_b) begin
                    state_d = OUT;
                    last_d  = 1'b0;
                    extra_d = 1'b1;
                end else begin
                    blk_d[poff +: 8] = blk_d[poff +: 8] | 8'h06;
                    blk_d[roff +: 8] = blk_d[roff +: 8] | 8'h80;
                    state_d = OUT;
                    last_d  = 1'b1;
                end
            end
            OUT: if (blk_ready) begin
                blk_d   = '0;
                wcnt_d  = '0;
                state_d = extra_q ? EXTRA : FILL;
                extra_d = 1'b0;
            end
            EXTRA: begin
                blk_d[7:0]       = 8'h06;
                blk_d[roff +: 8] = 8'h80;
                last_d  = 1'b1;
                state_d = OUT;
            end
            default: state_d = FILL;
        endcase
    end
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q  <= FILL;
            wcnt_q   <= '0;
            blk_q    <= '0;
            mode_q   <= '0;
            extra_q  <= 1'b0;
            last_q   <= 1'b0;
            in_msg_q <= 1'b0;
            run_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            blk_q    <= blk_d;
            mode_q   <= mode_d;
            extra_q  <= extra_d;
            last_q   <= last_d;
            in_msg_q <= in_msg_d;
            run_q    <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sha3_absorb_rx.sv
// tb_sha3_absorb_rx: directed checks of packing, padding, extra block, back-pressure and reset.
module tb_sha3_absorb_rx;
    logic          ACLK = 0, ARESETn = 0;
    logic [15:0]   s_axis_tdata = 0;
    logic          s_axis_tvalid = 0, s_axis_tlast = 0, blk_ready = 0;
    logic [1:0]    s_axis_tkeep = 0, s_axis_tuser = 0;
    logic          s_axis_tready, blk_valid, blk_last;
    logic [1151:0] blk_data, exp_blk;
    logic [1:0]    blk_mode;
    int            tests = 0, fails = 0;

    sha3_absorb_rx dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
        .blk_last(blk_last), .blk_mode(blk_mode)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_blk(input string tag, input logic lst, input logic [1:0] md);
        tests++;
        assert (blk_data === exp_blk) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, blk_data, exp_blk);
        end
        chk({tag, "_last"}, blk_last, lst);
        chk({tag, "_mode"}, blk_mode, md);
    endtask

    task automatic setb(input int k, input logic [7:0] v);
        exp_blk[8*k +: 8] = v;
    endtask

    task automatic beat(input logic [15:0] d, input logic l, input logic [1:0] k, input logic [1:0] u);
        int n = 0;
        s_axis_tdata = d; s_axis_tlast = l; s_axis_tkeep = k; s_axis_tuser = u; s_axis_tvalid = 1;
        @(negedge ACLK);
        while (!s_axis_tready && n < 50) begin @(negedge ACLK); n++; end
        chk("beat_timeout", n < 50, 1);
        @(posedge ACLK); #1;
        s_axis_tvalid = 0; s_axis_tlast = 0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!blk_valid && n < 20) begin @(negedge ACLK); n++; end
        chk("blk_valid_timeout", n < 20, 1);
    endtask

    task automatic blk_hs();
        @(negedge ACLK); blk_ready = 1;
        @(posedge ACLK); #1; blk_ready = 0;
    endtask

    initial begin
        // reset state
        #12;
        chk("rst_tready", s_axis_tready, 0);
        chk("rst_valid", blk_valid, 0);
        chk("rst_last", blk_last, 0);
        chk("rst_mode", blk_mode, 0);
        @(negedge ACLK); ARESETn = 1; #1;
        chk("rst_rel_tready", s_axis_tready, 0);
        @(posedge ACLK); #1;
        chk("first_edge_tready", s_axis_tready, 1);

        // empty message mode 3, with 10 cycles of back-pressure
        beat(16'h0000, 1, 2'b00, 2'd3);
        chk("empty_latency", blk_valid, 1);
        exp_blk = '0; setb(0, 8'h06); setb(71, 8'h80);
        chk_blk("empty", 1, 2'd3);
        for (int i = 0; i < 10; i++) begin
            @(negedge ACLK);
            chk_blk("hold", 1, 2'd3);
            chk("hold_tready", s_axis_tready, 0);
            chk("hold_valid", blk_valid, 1);
        end
        blk_hs();
        chk("empty_after_hs_valid", blk_valid, 0);
        chk("empty_after_hs_tready", s_axis_tready, 1);

        // single beat mode 1
        beat(16'hABCD, 1, 2'b11, 2'd1);
        exp_blk = '0; setb(0, 8'hAB); setb(1, 8'hCD); setb(2, 8'h06); setb(135, 8'h80);
        chk_blk("one_beat_m1", 1, 2'd1);
        blk_hs();

        // mode 3, 35 beats + high-byte-only last beat; later tuser/tkeep ignored
        exp_blk = '0;
        for (int i = 0; i < 35; i++) begin
            beat({8'(i), 8'(i + 100)}, 0, 2'b00, i == 0 ? 2'd3 : 2'd0);
            setb(2*i, 8'(i)); setb(2*i + 1, 8'(i + 100));
        end
        chk("m3_35_no_block", blk_valid, 0);
        beat(16'h1234, 1, 2'b10, 2'd1);
        setb(70, 8'h12); setb(71, 8'h86);
        chk_blk("m3_pad86", 1, 2'd3);
        blk_hs();
        chk("m3_pad86_single", blk_valid, 0);

        // mode 3, exactly 36 beats: data block then extra padding block
        exp_blk = '0;
        for (int i = 0; i < 36; i++) begin
            beat({8'(i), 8'(i + 100)}, i == 35, 2'b11, 2'd3);
            setb(2*i, 8'(i)); setb(2*i + 1, 8'(i + 100));
        end
        chk_blk("m3_full_blk1", 0, 2'd3);
        chk("m3_full_tready1", s_axis_tready, 0);
        blk_hs();
        chk("m3_extra_tready", s_axis_tready, 0);
        chk("m3_extra_valid", blk_valid, 0);
        @(negedge ACLK);
        wait_valid();
        exp_blk = '0; setb(0, 8'h06); setb(71, 8'h80);
        chk_blk("m3_full_blk2", 1, 2'd3);
        chk("m3_full_tready2", s_axis_tready, 0);
        blk_hs();
        chk("m3_full_done_tready", s_axis_tready, 1);

        // mode 2: full non-last block, then mode persists into next block
        exp_blk = '0;
        for (int i = 0; i < 52; i++) begin
            beat({8'(i), 8'(i + 60)}, 0, 2'b11, i == 0 ? 2'd2 : 2'd1);
            setb(2*i, 8'(i)); setb(2*i + 1, 8'(i + 60));
        end
        chk_blk("m2_blk1", 0, 2'd2);
        blk_hs();
        beat(16'hBEEF, 1, 2'b11, 2'd0);
        exp_blk = '0; setb(0, 8'hBE); setb(1, 8'hEF); setb(2, 8'h06); setb(103, 8'h80);
        chk_blk("m2_blk2", 1, 2'd2);
        blk_hs();

        // reset mid-message discards partial data
        for (int i = 0; i < 10; i++) beat(16'hFFFF, 0, 2'b11, 2'd2);
        @(negedge ACLK); ARESETn = 0; #1;
        chk("midrst_tready", s_axis_tready, 0);
        chk("midrst_valid", blk_valid, 0);
        @(negedge ACLK); ARESETn = 1;
        @(posedge ACLK); #1;
        beat(16'h5A3C, 1, 2'b11, 2'd0);
        exp_blk = '0; setb(0, 8'h5A); setb(1, 8'h3C); setb(2, 8'h06); setb(143, 8'h80);
        chk_blk("post_rst_m0", 1, 2'd0);
        blk_hs();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sha3_absorb_rx.md
SHA3_ABSORB_RX -- requirements
Module: sha3_absorb_rx

Interface
REQ-001 Parameter: WIDTH, 16, stream data width in bits; only 16 is supported.
REQ-002 Parameter: RATE_MAX, 1152, block register width in bits, equal to the SHA3-224 rate.
REQ-003 Clock/reset: one clock; reset is asynchronous and active-low.
REQ-004 Ports SHALL be as follows:
- ACLK  in  1  clock, all logic on rising edge.
- ARESETn  in  1  asynchronous active-low reset.
- s_axis_tdata  in  16  message data; byte order [15:8] first, then [7:0].
- s_axis_tvalid  in  1  beat valid.
- s_axis_tready  out  1  beat accepted when tvalid&tready.
- s_axis_tlast  in  1  final beat of the message.
- s_axis_tkeep  in  2  byte enables, honoured on the tlast beat only: 11, 10 (high byte only) or 00 (no bytes).
- s_axis_tuser  in  2  mode select: 0=SHA3-224, 1=SHA3-256, 2=SHA3-384, 3=SHA3-512.
- blk_valid  out  1  padded rate block available.
- blk_ready  in  1  permutation core accepts the block.
- blk_data  out  1152  block; byte k is at [8k+7:8k]; bytes at or beyond the rate are 0.
- blk_last  out  1  block is the final, padded block of the message.
- blk_mode  out  2  latched mode of the current message.

Function
REQ-005 Rate in bytes per mode SHALL be 144/136/104/72, i.e. 72/68/52/36 words.
REQ-006 The FSM SHALL have states FILL, OUT and EXTRA; s_axis_tready = (state==FILL).
REQ-007 The mode SHALL be latched from tuser on the first accepted beat of each message; tuser SHALL be ignored for the rest of that message.
REQ-008 An accepted non-last beat SHALL write byte 2*wcnt = tdata[15:8] and byte 2*wcnt+1 = tdata[7:0], then increment wcnt.
REQ-009 If a non-last beat fills the rate (wcnt == rate_words-1), the FSM SHALL go FILL->OUT with blk_last=0, and blk_valid SHALL rise on the next cycle.
REQ-010 On an accepted tlast beat, let p = the count of message bytes in the block after that beat's kept bytes are written.
- If p < rate: byte p |= 0x06, byte rate-1 |= 0x80 (0x86 if p == rate-1).
- The FSM SHALL go to OUT with blk_last=1.
REQ-011 On a tlast beat with p == rate: the FSM SHALL go to OUT with blk_last=0, and an extra-block flag SHALL be set.
REQ-012 In OUT:
- blk_valid=1, and blk_data, blk_last and blk_mode SHALL stay stable until blk_valid&blk_ready.
- On that handshake: the block register clears to 0, wcnt=0.
- Next state: EXTRA if the extra-block flag is set (flag cleared), else FILL.
REQ-013 EXTRA SHALL last one cycle: byte0=0x06, byte rate-1=0x80, blk_last=1, then go to OUT.
REQ-014 Latency SHALL be 1 cycle from the completing beat handshake to blk_valid=1, and 1 cycle from the blk handshake back to tready=1 (FILL case).
REQ-015 A tlast beat with tkeep=00 and wcnt=0 (empty message) SHALL produce a single block: 0x06 at byte 0, 0x80 at byte rate-1.
REQ-016 tkeep on non-last beats SHALL be ignored and treated as 11.
REQ-017 The blk interface SHALL NOT accept a new beat in the same cycle as a blk handshake; tready stays 0 in that cycle.

Reset
REQ-018 While ARESETn=0, the block SHALL hold: state=FILL, wcnt=0, block register=0, extra flag=0, mode=0, s_axis_tready=0, blk_valid=0, blk_last=0, blk_mode=0.
REQ-019 tready SHALL rise on the first ACLK edge after ARESETn deasserts.
REQ-020 Reset mid-message or mid-OUT SHALL discard all partial data; the next beat starts a new message at byte 0.

Verification
REQ-021 Empty message, mode 3 (one beat, tlast=1, tkeep=00) -> one block: byte0=0x06, byte71=0x80, all other bytes 0, blk_last=1.
REQ-022 Mode 1, single beat 0xABCD, tkeep=11, tlast=1 -> bytes 0:0xAB, 1:0xCD, 2:0x06, 135:0x80, bytes 136..143=0, blk_last=1.
REQ-023 Mode 3: 35 full beats, then 0x1234 with tkeep=10, tlast=1 -> byte70=0x12, byte71=0x86, blk_last=1, single block.
REQ-024 Mode 3: exactly 36 beats with the last one tlast=1 -> block 1 carries the data with blk_last=0; block 2 = 0x06 at byte 0, 0x80 at byte 71, blk_last=1; tready=0 from the 36th beat until block 2 is accepted.
REQ-025 blk_ready held 0 for 10 cycles while blk_valid=1 -> blk_data, blk_last and blk_mode are unchanged and tready=0 throughout; one handshake on blk_ready=1.
REQ-026 ARESETn pulsed low after 10 beats of a mode 2 message, then a 1-beat message in mode 0 -> output block has mode 0 (rate 144), no residue from the first message, blk_mode=0.
